sqrt_arbiter: RTL

Round-robin scheduler that shares one iterative square-root datapath among `M` requesters. It accepts at most one request at a time using a valid/ready handshake per requester. It runs the non-restoring integer square root (one result bit per cycle), then returns root, remainder and requester ID on a single response channel with backpressure. It sits between the client blocks and the square-root datapath and is the only block that drives the datapath.

---
 rtl/sqrt_pkg.sv | 37 +++
 rtl/sqrt_iter.sv | 84 ++++++++
 rtl/sqrt_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and helpers for the square-root arbiter slice.
//   state_t        - arbiter FSM states
//   SQRT_N_DEFAULT - default operand width
//   rr_pick()      - round-robin search: first set bit at or after ptr, wrapping at m
package sqrt_pkg;

    localparam int SQRT_N_DEFAULT = 16;

    // Widest requester vector rr_pick() can search; callers zero-extend into it.
    localparam int RR_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns the index of the first set bit of valid[m-1:0] found by scanning
    // ptr, ptr+1, ... with wrap at m; -1 when nothing is set. The scan walks
    // offsets from high to low so the smallest offset overwrites last and wins.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                   input int ptr,
                                   input int m);
        int idx;
        rr_pick = -1;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (i < m) begin
                idx = ptr + i;
                if (idx >= m)
                    idx = idx - m;
                if (valid[idx])
                    rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/sqrt_iter.sv
// sqrt_iter: non-restoring integer square root, one root bit per clock.
//   Clock, reset_n : clock / async active-low reset
//   start          : load num and begin; N/2 iteration cycles follow
//   num[N-1:0]     : operand, sampled on the start edge
//   root[N/2-1:0]  : floor(sqrt(num)), valid while done is high
//   rem[N/2:0]     : num - root^2 (corrected, non-negative), valid with done
//   done           : one-cycle strobe during the final iteration cycle
// root/rem are the combinational result of the final iteration so the owner
// can latch them on the same edge that retires the last bit.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int N = SQRT_N_DEFAULT
) (
    input  logic           Clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   num,
    output logic [N/2-1:0] root,
    output logic [N/2:0]   rem,
    output logic           done
);

    localparam int H  = N / 2;
    localparam int RW = H + 2;                    // partial remainder, two's complement
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    logic [N-1:0]  num_sh;     // operand bit pairs, consumed MSB-first
    logic [RW-1:0] r;
    logic [H-1:0]  q;
    logic [CW-1:0] cnt;
    logic          running;

    logic [RW-1:0] r_sh;
    logic [RW-1:0] r_nx;
    logic [RW-1:0] r_fix;
    logic [H-1:0]  q_nx;

    always_comb begin
        r_sh = {r[RW-3:0], num_sh[N-1:N-2]};
        // Sign of the running remainder picks subtract (try 4q+1) or
        // add back (4q+3) instead of restoring.
        if (!r[RW-1])
            r_nx = r_sh - {q, 2'b01};
        else
            r_nx = r_sh + {q, 2'b11};
        q_nx = {q[H-2:0], ~r_nx[RW-1]};
        // A negative final remainder needs one add of 2q+1 to become exact.
        if (r_nx[RW-1])
            r_fix = r_nx + RW'({q_nx, 1'b1});
        else
            r_fix = r_nx;
        root = q_nx;
        rem  = r_fix[H:0];
        done = running && (cnt == CW'(H - 1));
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            num_sh  <= '0;
            r       <= '0;
            q       <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            num_sh  <= num;
            r       <= '0;
            q       <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            r      <= r_nx;
            q      <= q_nx;
            num_sh <= {num_sh[N-3:0], 2'b00};
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end sharing one sqrt_iter among M clients.
//   Clock, reset_n        : clock / async active-low reset
//   req_valid[M-1:0]      : per-requester valid
//   req_data[M*N-1:0]     : operands, requester k at [k*N +: N]
//   req_ready[M-1:0]      : one-hot accept strobe for the IDLE winner
//   rsp_valid / rsp_ready : response handshake
//   rsp_id, rsp_root, rsp_rem : owner ID, floor(sqrt), operand - root^2
//   busy                  : high while RUN or RESP
module sqrt_arbiter
    import sqrt_pkg::*;
#(
    parameter int N   = SQRT_N_DEFAULT,
    parameter int M   = 4,
    parameter int IDW = $clog2(M)
) (
    input  logic             Clock,
    input  logic             reset_n,
    input  logic [M-1:0]     req_valid,
    input  logic [M*N-1:0]   req_data,
    output logic [M-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N/2-1:0]   rsp_root,
    output logic [N/2:0]     rsp_rem,
    output logic             busy
);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;

    logic [RR_MAX-1:0] valid_ext;
    int               ptr;
    int               win;
    logic [IDW-1:0]   win_id;
    logic             accept;
    logic [N-1:0]     core_num;
    logic [N/2-1:0]   core_root;
    logic [N/2:0]     core_rem;
    logic             core_done;

    always_comb begin
        valid_ext          = '0;
        valid_ext[M-1:0]   = req_valid;
        ptr = (int'(last_grant) == M - 1) ? 0 : int'(last_grant) + 1;
        win = rr_pick(valid_ext, ptr, M);
        win_id = (win >= 0) ? IDW'(win) : '0;
        // Grant is combinational from valid and pointer; held off during
        // reset so nothing looks accepted while reset_n is low.
        req_ready = '0;
        if (reset_n && state == IDLE && win >= 0)
            req_ready[win_id] = 1'b1;
        accept   = |(req_valid & req_ready);
        core_num = req_data[win_id*N +: N];
    end

    sqrt_iter #(.N(N)) u_iter (
        .Clock   (Clock),
        .reset_n (reset_n),
        .start   (accept),
        .num     (core_num),
        .root    (core_root),
        .rem     (core_rem),
        .done    (core_done)
    );

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= IDW'(M - 1);
            cur_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_root   <= '0;
            rsp_rem    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= win_id;
                        cur_id     <= win_id;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_id    <= cur_id;
                        rsp_root  <= core_root;
                        rsp_rem   <= core_rem;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Return to IDLE only; the next accept waits a cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
